// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the 32-entry register file: register count,
// index width, the hardwired zero register index and the index type.
// No ports (package).
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t ZERO_REG = 5'd0;

endpackage : regfile_pkg

// File: rtl/regfile_decode_32_decoder.sv
// -----------------------------------------------------------------------------
// Write-side one-hot decoders for the register file.
//
// decoder_2  : sel_i (1b), en_i -> dec_o (2b one-hot, all zero when en_i=0)
// decoder_4  : sel_i (2b), en_i -> dec_o (4b one-hot), two levels of decoder_2
// decoder_32 : idx_i (5b), en_i -> dec_o (32b one-hot)
//
// decoder_32 is the mirror image of the read mux tree: the top index bit picks
// one of two halves, then two 2-bit stages narrow it down to a single register.
// Enables ripple downward, so at most one output bit is ever set.
// -----------------------------------------------------------------------------

module decoder_2 (
    input  logic       sel_i,
    input  logic       en_i,
    output logic [1:0] dec_o
);
    assign dec_o[0] = en_i & ~sel_i;
    assign dec_o[1] = en_i &  sel_i;
endmodule : decoder_2


module decoder_4 (
    input  logic [1:0] sel_i,
    input  logic       en_i,
    output logic [3:0] dec_o
);
    logic [1:0] en_half;

    decoder_2 u_hi (
        .sel_i (sel_i[1]),
        .en_i  (en_i),
        .dec_o (en_half)
    );

    decoder_2 u_lo0 (
        .sel_i (sel_i[0]),
        .en_i  (en_half[0]),
        .dec_o (dec_o[1:0])
    );

    decoder_2 u_lo1 (
        .sel_i (sel_i[0]),
        .en_i  (en_half[1]),
        .dec_o (dec_o[3:2])
    );
endmodule : decoder_4


module decoder_32
    import regfile_pkg::*;
(
    input  logic [REG_IDX_W-1:0] idx_i,
    input  logic                 en_i,
    output logic [NUM_REGS-1:0]  dec_o
);
    logic [1:0] en_hi;   // selected by idx_i[4]
    logic [7:0] en_mid;  // selected by idx_i[4:2]

    decoder_2 u_top (
        .sel_i (idx_i[4]),
        .en_i  (en_i),
        .dec_o (en_hi)
    );

    for (genvar g = 0; g < 2; g++) begin : g_mid
        decoder_4 u_mid (
            .sel_i (idx_i[3:2]),
            .en_i  (en_hi[g]),
            .dec_o (en_mid[4*g +: 4])
        );
    end

    for (genvar g = 0; g < 8; g++) begin : g_low
        decoder_4 u_low (
            .sel_i (idx_i[1:0]),
            .en_i  (en_mid[g]),
            .dec_o (dec_o[4*g +: 4])
        );
    end
endmodule : decoder_32

// File: rtl/regfile_decode_32_mux.sv
// -----------------------------------------------------------------------------
// mux_32
// 32:1 read-select mux, built as a five-level tree of 2:1 selects (LSB of the
// index steers the first level). One instance per read port.
//
// Ports:
//   data_i : 32 x WIDTH input words
//   sel_i  : 5-bit word index
//   data_o : selected word (combinational)
// -----------------------------------------------------------------------------
module mux_32
    import regfile_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [NUM_REGS-1:0][WIDTH-1:0] data_i,
    input  logic [REG_IDX_W-1:0]           sel_i,
    output logic [WIDTH-1:0]               data_o
);
    logic [15:0][WIDTH-1:0] lvl16;
    logic [7:0][WIDTH-1:0]  lvl8;
    logic [3:0][WIDTH-1:0]  lvl4;
    logic [1:0][WIDTH-1:0]  lvl2;

    always_comb begin
        lvl16 = '0;
        for (int k = 0; k < 16; k++) begin
            lvl16[k] = sel_i[0] ? data_i[2*k+1] : data_i[2*k];
        end
    end

    always_comb begin
        lvl8 = '0;
        for (int k = 0; k < 8; k++) begin
            lvl8[k] = sel_i[1] ? lvl16[2*k+1] : lvl16[2*k];
        end
    end

    always_comb begin
        lvl4 = '0;
        for (int k = 0; k < 4; k++) begin
            lvl4[k] = sel_i[2] ? lvl8[2*k+1] : lvl8[2*k];
        end
    end

    always_comb begin
        lvl2 = '0;
        for (int k = 0; k < 2; k++) begin
            lvl2[k] = sel_i[3] ? lvl4[2*k+1] : lvl4[2*k];
        end
    end

    assign data_o = sel_i[4] ? lvl2[1] : lvl2[0];
endmodule : mux_32

// File: rtl/regfile_decode_32.sv
// -----------------------------------------------------------------------------
// regfile_decode_32
// 32 x DATA_WIDTH register file: one write port (writeback), two combinational
// read ports (decode). Register 0 is hardwired to zero. With BYPASS=1 the
// write port is forwarded to any read port addressing the register being
// written in the same cycle.
//
// Ports:
//   clock        : rising-edge clock
//   reset        : asynchronous, active-high; clears every register
//   write_enable : commit write_data to write_reg on the next rising edge
//   write_reg    : destination index
//   write_data   : data to write
//   read_reg_a/b : read indices
//   read_data_a/b: register contents (combinational, bypassed if enabled)
// -----------------------------------------------------------------------------
module regfile_decode_32
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic [REG_IDX_W-1:0]  write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [REG_IDX_W-1:0]  read_reg_a,
    input  logic [REG_IDX_W-1:0]  read_reg_b,
    output logic [DATA_WIDTH-1:0] read_data_a,
    output logic [DATA_WIDTH-1:0] read_data_b
);
    logic [NUM_REGS-1:0]                 dec;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
    logic [DATA_WIDTH-1:0]               stored_a;
    logic [DATA_WIDTH-1:0]               stored_b;
    logic                                wr_live;
    logic                                fwd_a;
    logic                                fwd_b;

    decoder_32 u_dec (
        .idx_i (write_reg),
        .en_i  (write_enable),
        .dec_o (dec)
    );

    // Register 0 has no storage; its decode bit only serves to veto the bypass.
    assign regs[ZERO_REG] = '0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        logic [DATA_WIDTH-1:0] reg_d;
        logic [DATA_WIDTH-1:0] reg_q;

        assign reg_d = dec[i] ? write_data : reg_q;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                reg_q <= '0;
            end else begin
                reg_q <= reg_d;
            end
        end

        assign regs[i] = reg_q;
    end

    mux_32 #(.WIDTH(DATA_WIDTH)) u_mux_a (
        .data_i (regs),
        .sel_i  (read_reg_a),
        .data_o (stored_a)
    );

    mux_32 #(.WIDTH(DATA_WIDTH)) u_mux_b (
        .data_i (regs),
        .sel_i  (read_reg_b),
        .data_o (stored_b)
    );

    // A write is forwardable only if it will actually land: enabled, not aimed
    // at r0 (dec[0] flags exactly that case) and not being cancelled by reset.
    assign wr_live = write_enable & ~dec[ZERO_REG] & ~reset;
    assign fwd_a   = BYPASS && wr_live && (read_reg_a == write_reg);
    assign fwd_b   = BYPASS && wr_live && (read_reg_b == write_reg);

    assign read_data_a = fwd_a ? write_data : stored_a;
    assign read_data_b = fwd_b ? write_data : stored_b;
endmodule : regfile_decode_32

// File: tb/tb_regfile_decode_32.sv
// -----------------------------------------------------------------------------
// Bench for regfile_decode_32. Two instances share all inputs: one with
// BYPASS=0, one with BYPASS=1. Expected reads come from a plain array model.
// -----------------------------------------------------------------------------
module tb_regfile_decode_32;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        write_enable = 1'b0;
    logic [4:0]  write_reg = '0;
    logic [31:0] write_data = '0;
    logic [4:0]  read_reg_a = '0;
    logic [4:0]  read_reg_b = '0;
    logic [31:0] a0, b0, a1, b1;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] model [32];
    string       port_name [4] = '{"nobyp_a", "nobyp_b", "byp_a", "byp_b"};

    always #5 clock = ~clock;

    regfile_decode_32 #(.DATA_WIDTH(32), .BYPASS(1'b0)) u_nobyp (
        .clock        (clock),
        .reset        (reset),
        .write_enable (write_enable),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .read_reg_a   (read_reg_a),
        .read_reg_b   (read_reg_b),
        .read_data_a  (a0),
        .read_data_b  (b0)
    );

    regfile_decode_32 #(.DATA_WIDTH(32), .BYPASS(1'b1)) u_byp (
        .clock        (clock),
        .reset        (reset),
        .write_enable (write_enable),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .read_reg_a   (read_reg_a),
        .read_reg_b   (read_reg_b),
        .read_data_a  (a1),
        .read_data_b  (b1)
    );

    // ---------------- reference model ----------------
    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] idx);
        if (reset) return '0;
        if (byp && write_enable && write_reg != 0 && idx == write_reg) return write_data;
        if (idx == 0) return '0;
        return model[idx];
    endfunction

    // Advance one rising edge, apply the edge to the model, land 1 time unit after.
    task automatic tick();
        @(posedge clock);
        if (reset) clear_model();
        else if (write_enable && write_reg != 0) model[write_reg] = write_data;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] got [4];
        tick();
        write_enable = 1'b1; write_reg = 5'd5; write_data = 32'h1111_2222;
        read_reg_a = 5'd5; read_reg_b = 5'd5;
        for (int c = 0; c < 2; c++) begin
            #1;
            got = '{a0, b0, a1, b1};
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (got[k] !== 32'h0) begin
                    n_fail++;
                    $display("FAIL reset_hold %s cyc%0d: got %h expected %h", port_name[k], c, got[k], 32'h0);
                end
            end
            tick();
        end
        reset = 1'b0; write_enable = 1'b0;
        #1;
        got = '{a0, b0, a1, b1};
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (got[k] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_release %s: got %h expected %h", port_name[k], got[k], 32'h0);
            end
        end
    endtask

    task automatic test_reset_midsim();
        logic [31:0] got [4];
        logic [31:0] exp [4];
        write_enable = 1'b1; write_reg = 5'd5; write_data = 32'hDEAD_BEEF;
        read_reg_a = 5'd5; read_reg_b = 5'd9;
        tick();
        write_enable = 1'b0;
        #1;
        n_cmp++;
        if (a0 !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL midsim_prewrite nobyp_a: got %h expected %h", a0, 32'hDEAD_BEEF);
        end
        reset = 1'b1;
        clear_model();
        #1;
        got = '{a0, b0, a1, b1};
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (got[k] !== 32'h0) begin
                n_fail++;
                $display("FAIL midsim_async_reset %s: got %h expected %h", port_name[k], got[k], 32'h0);
            end
        end
        tick();
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            got = '{a0, b0, a1, b1};
            exp = '{exp_rd(0, read_reg_a), exp_rd(0, read_reg_b), exp_rd(1, read_reg_a), exp_rd(1, read_reg_b)};
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (got[k] !== exp[k]) begin
                    n_fail++;
                    $display("FAIL midsim_after %s cyc%0d: got %h expected %h", port_name[k], c, got[k], exp[k]);
                end
            end
            tick();
        end
    endtask

    // Write r<idx>=data while both ports read r<idx>; check before and after the edge.
    task automatic test_write_read(input string tag, input logic [4:0] idx, input logic [31:0] data);
        logic [31:0] got [4];
        logic [31:0] exp [4];
        write_enable = 1'b1; write_reg = idx; write_data = data;
        read_reg_a = idx; read_reg_b = idx;
        for (int c = 0; c < 2; c++) begin
            #1;
            got = '{a0, b0, a1, b1};
            exp = '{exp_rd(0, read_reg_a), exp_rd(0, read_reg_b), exp_rd(1, read_reg_a), exp_rd(1, read_reg_b)};
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (got[k] !== exp[k]) begin
                    n_fail++;
                    $display("FAIL %s %s cyc%0d: got %h expected %h", tag, port_name[k], c, got[k], exp[k]);
                end
            end
            tick();
            write_enable = 1'b0;
        end
    endtask

    task automatic test_decoder_exhaustive();
        logic [31:0] exp_a, exp_b;
        for (int i = 1; i < 32; i++) begin
            write_enable = 1'b1; write_reg = 5'(i); write_data = 32'((i << 8) | i);
            tick();
        end
        write_enable = 1'b0;
        for (int i = 1; i < 32; i++) begin
            read_reg_a = 5'(i); read_reg_b = 5'(32 - i);
            #1;
            exp_a = 32'((i << 8) | i);
            exp_b = 32'(((32 - i) << 8) | (32 - i));
            n_cmp++;
            if (a0 !== exp_a || a1 !== exp_a) begin
                n_fail++;
                $display("FAIL decode_a r%0d: got %h/%h expected %h", i, a0, a1, exp_a);
            end
            n_cmp++;
            if (b0 !== exp_b || b1 !== exp_b) begin
                n_fail++;
                $display("FAIL decode_b r%0d: got %h/%h expected %h", 32 - i, b0, b1, exp_b);
            end
        end
    endtask

    task automatic test_reset_collision();
        write_enable = 1'b1; write_reg = 5'd3; write_data = 32'hA5A5_A5A5;
        read_reg_a = 5'd3; read_reg_b = 5'd17;
        #1;
        reset = 1'b1;
        clear_model();
        tick();
        reset = 1'b0; write_enable = 1'b0;
        #1;
        n_cmp++;
        if (a0 !== 32'h0 || a1 !== 32'h0) begin
            n_fail++;
            $display("FAIL collision_r3: got %h/%h expected %h", a0, a1, 32'h0);
        end
        n_cmp++;
        if (b0 !== 32'h0 || b1 !== 32'h0) begin
            n_fail++;
            $display("FAIL collision_r17: got %h/%h expected %h", b0, b1, 32'h0);
        end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] got [4];
        logic [31:0] exp [4];
        for (int c = 0; c < 400; c++) begin
            write_enable = 1'($urandom_range(0, 1));
            write_reg    = 5'($urandom_range(0, 31));
            write_data   = $urandom;
            read_reg_a   = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
            read_reg_b   = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
            reset        = ($urandom_range(0, 40) == 0);
            if (reset) clear_model();
            #1;
            got = '{a0, b0, a1, b1};
            exp = '{exp_rd(0, read_reg_a), exp_rd(0, read_reg_b), exp_rd(1, read_reg_a), exp_rd(1, read_reg_b)};
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (got[k] !== exp[k]) begin
                    n_fail++;
                    $display("FAIL random %s cyc%0d ra=%0d rb=%0d wr=%0d we=%0b: got %h expected %h",
                             port_name[k], c, read_reg_a, read_reg_b, write_reg, write_enable, got[k], exp[k]);
                end
            end
            tick();
        end
        reset = 1'b0;
        write_enable = 1'b0;
    endtask

    initial begin
        clear_model();
        test_reset();
        test_reset_midsim();
        test_write_read("basic_r7", 5'd7, 32'h1234_5678);
        test_write_read("bypass_r31", 5'd31, 32'hCAFE_F00D);
        test_write_read("zero_reg", 5'd0, 32'hFFFF_FFFF);
        test_decoder_exhaustive();
        test_reset_collision();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_regfile_decode_32

// File: doc/regfile_decode_32.md
# regfile_decode_32

Thirty-two-entry, 32-bit register file for the 5-stage pipeline. The write side is a 5-to-32 one-hot decoder that gates per-register write enables, the counterpart to the 32:1 read-select mux tree. It provides one write port, driven by writeback, and two read ports, driven by decode. Register 0 is hardwired to zero, and an optional write-to-read bypass removes the writeback/decode structural hazard.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = reads return stored value only

Ports:
- clock  in  1  single clock; all register updates on rising edge
- reset  in  1  asynchronous, active-high; clears all registers immediately
- write_enable  in  1  commit write_data to register write_reg on next rising edge
- write_reg  in  5  destination register index
- write_data  in  DATA_WIDTH  data to write
- read_reg_a  in  5  read port A index
- read_reg_b  in  5  read port B index
- read_data_a  out  DATA_WIDTH  contents of register read_reg_a (combinational)
- read_data_b  out  DATA_WIDTH  contents of register read_reg_b (combinational)

## Operation
- Storage is 32 registers, reg[0..31], each DATA_WIDTH bits.
- Write decode: decoder_32 produces a one-hot enable `dec[i] = write_enable && (write_reg == i)`. At most one bit of `dec` is set.
- Register i (i ≥ 1) loads write_data on a rising clock edge when `dec[i]` is set. Otherwise it holds its value.
- Register 0 never loads and always reads 0. A write to index 0 is silently discarded.
- Read ports are independent combinational selects of the register array. Both ports may address the same register, and each may equal write_reg.
- Bypass, when BYPASS=1: if write_enable=1, write_reg≠0 and read_reg_x==write_reg, then read_data_x = write_data in the same cycle. The bypass is applied to each read port independently.
- With BYPASS=0 the read returns the pre-write value until the edge, and the new value after it.
- Reset:
  - While reset is high, all registers are 0 and all writes are ignored.
  - The bypass is suppressed while reset is high, so read_data_a = read_data_b = 0.
  - Deassertion takes effect on the first rising edge after reset falls.
- Reset during a write: reset wins, and the register stays 0.
- Unused upper data bits do not exist: all data paths are exactly DATA_WIDTH. There is no sign extension or truncation.

## Timing
- Write latency: 1 cycle. Data is presented in cycle N and is visible through the stored path from cycle N+1.
- Read latency: 0 cycles, combinational from read_reg_x, the register array, and (when BYPASS=1) the write inputs.
- Bypass path: combinational from write_data/write_reg/write_enable to read_data_x. The writeback → decode combinational path must close in one cycle.
- Reset values: every register is 0, so both read outputs are 0 during and immediately after reset.
- Simultaneous events in one cycle:
  - Write and read to the same index: bypass value when BYPASS=1, old value when BYPASS=0.
  - Both read ports on the write index: both receive the same value.
  - Write to index 0 together with a read of index 0: the read returns 0.
- There is no handshake and no stall: a write is accepted every cycle in which write_enable=1.

## Structure
- Shared package `regfile_pkg`:
  - `NUM_REGS=32`
  - `REG_IDX_W=5`
  - `ZERO_REG=5'd0`
  - typedef `reg_idx_t` (5-bit)
- Sub-modules:
  - `decoder_32`: 5-bit index plus enable in, 32-bit one-hot out. It is the write-side counterpart of the read mux tree, built hierarchically from decoder_2 / decoder_4 stages mirroring the mux hierarchy.
  - `mux_32`: reused unchanged for each read port.
- Register storage is one generate loop of 31 DATA_WIDTH-bit flops, indices 1..31, each with async reset.

## Test plan
- **Reset:** assert reset mid-sim after writing 0xDEADBEEF to r5 → read_data_a (read_reg_a=5) = 0 immediately. After deassert it stays 0 until written.
- **Basic write/read:**
  - Write 0x12345678 to r7 in cycle N, BYPASS=0.
  - Read r7 in cycle N → old value (0). Cycle N+1 → 0x12345678.
- **Bypass:** BYPASS=1, write 0xCAFEF00D to r31 with read_reg_a=read_reg_b=31 in the same cycle → both outputs = 0xCAFEF00D before the edge.
- **Zero register:**
  - Write 0xFFFFFFFF to r0.
  - Read r0 on both ports, during the write cycle and after it → 0 always, including with BYPASS=1.
- **Decoder exhaustive:**
  - Write value (i<<8)|i to each r1..r31 in sequence.
  - Read all pairs (i, 32−i) → each port returns its register's own value. No aliasing, and no register other than the target changes.
- **Reset collision:** assert reset on the same edge as write r3=0xA5A5A5A5 → r3 reads 0 after reset deasserts.
